// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_queue
//  Purpose  : Fetch PC, credit-limited imem requests and an in-order
//             instruction/PC FIFO feeding decode, with redirect flush.
//  Revision : 1.0
// ============================================================================
module instr_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    input  logic            dec_ready
);

    localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CNT_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0]  LIMIT    = (CNT_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [XLEN-1:0] STEP     = XLEN'(4);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [XLEN-1:0]  instr_mem_q [DEPTH];
    logic [XLEN-1:0]  pc_mem_q    [DEPTH];

    logic             w_credit_ok;
    logic             w_req_hs;
    logic             w_push;
    logic             w_pop;
    logic [XLEN-1:0]  w_redirect_pc;
    logic             w_unused;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Credit: in-flight plus buffered never exceeds DEPTH, so responses always fit.
    assign w_credit_ok    = ({1'b0, outstanding_q} + {1'b0, count_q}) < LIMIT;
    assign imem_req_valid = !rst && !redirect_valid && w_credit_ok;
    assign imem_req_addr  = pc_q;
    assign w_req_hs       = imem_req_valid && imem_req_ready;
    assign w_redirect_pc  = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_unused       = ^redirect_pc[1:0];

    assign if_valid = (count_q != '0);
    assign if_instr = if_valid ? instr_mem_q[head_q] : '0;
    assign if_pc    = if_valid ? pc_mem_q[head_q]    : '0;

    always_comb begin
        pc_d          = pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        count_d       = count_q;
        head_d        = head_q;
        tail_d        = tail_q;
        w_push        = 1'b0;
        w_pop         = 1'b0;
        if (redirect_valid) begin
            // Every response still owed after this cycle belongs to the old path.
            outstanding_d = outstanding_q - CNT_W'(imem_rsp_valid);
            drop_d        = outstanding_d;
            count_d       = '0;
            head_d        = '0;
            tail_d        = '0;
            pc_d          = w_redirect_pc;
            resp_pc_d     = w_redirect_pc - XLEN'({outstanding_d, 2'b00});
        end else begin
            w_pop = if_valid && dec_ready;
            if (imem_rsp_valid) begin
                resp_pc_d = resp_pc_q + STEP;
                if (drop_q != '0) begin
                    drop_d = drop_q - CNT_W'(1);
                end else begin
                    w_push = 1'b1;
                end
            end
            outstanding_d = outstanding_q + CNT_W'(w_req_hs) - CNT_W'(imem_rsp_valid);
            if (w_req_hs) begin
                pc_d = pc_q + STEP;
            end
            if (w_push) begin
                tail_d = ptr_inc(tail_q);
            end
            if (w_pop) begin
                head_d = ptr_inc(head_q);
            end
            count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            count_q       <= '0;
            head_q        <= '0;
            tail_q        <= '0;
        end else begin
            pc_q          <= pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            count_q       <= count_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            instr_mem_q[tail_q] <= imem_rsp_data;
            pc_mem_q[tail_q]    <= resp_pc_q;
        end
    end

`ifndef SYNTHESIS
    a_credit: assert property (@(posedge clk) disable iff (rst)
        ({1'b0, outstanding_q} + {1'b0, count_q}) <= LIMIT);
    a_drop_le_out: assert property (@(posedge clk) disable iff (rst)
        drop_q <= outstanding_q);
    a_no_spurious_rsp: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (outstanding_q != '0));
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch_queue
//  Purpose  : Directed bench for instr_fetch_queue with an in-order imem model.
//  Revision : 1.0
// ============================================================================
module tb_instr_fetch_queue;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        dec_ready;

    int          n_tests;
    int          n_fail;
    logic        hold;
    logic [31:0] pend[$];

    instr_fetch_queue #(
        .XLEN    (32),
        .DEPTH   (4),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .dec_ready     (dec_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: memory returns each accepted address as data, in order,
    // one cycle later unless held.
    task automatic cycle();
        logic        hs;
        logic [31:0] a;
        hs = imem_req_valid && imem_req_ready;
        a  = imem_req_addr;
        @(posedge clk);
        #1;
        if (hs) pend.push_back(a);
        if (!hold && pend.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = pend.pop_front();
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        pend.delete();
        #1;
        cycle();
        cycle();
        pend.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        rst            = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        hold           = 1'b0;
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_ready      = 1'b1;

        // Reset state
        @(posedge clk);
        #1;
        chk("rst_if_valid",  32'(if_valid), 32'd0);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_if_pc",     if_pc, 32'd0);
        chk("rst_if_instr",  if_instr, 32'd0);
        cycle();
        pend.delete();
        imem_rsp_valid = 1'b0;
        rst = 1'b0;
        #1;

        // Streaming: one instruction per cycle from cycle 2
        chk("t1_req_valid_c0", 32'(imem_req_valid), 32'd1);
        chk("t1_req_addr_c0",  imem_req_addr, 32'd0);
        cycle(); #1;
        chk("t1_if_valid_c1",  32'(if_valid), 32'd0);
        chk("t1_req_addr_c1",  imem_req_addr, 32'd4);
        for (int k = 2; k < 10; k++) begin
            cycle(); #1;
            chk("t1_if_valid", 32'(if_valid), 32'd1);
            chk("t1_if_pc",    if_pc, 32'(4 * (k - 2)));
            chk("t1_if_instr", if_instr, 32'(4 * (k - 2)));
            chk("t1_req_addr", imem_req_addr, 32'(4 * k));
        end

        // Backpressure: queue fills to DEPTH, then drains in order
        do_reset();
        dec_ready = 1'b0;
        #1;
        repeat (10) cycle();
        #1;
        chk("t2_full_if_valid",  32'(if_valid), 32'd1);
        chk("t2_full_if_pc",     if_pc, 32'd0);
        chk("t2_full_req_valid", 32'(imem_req_valid), 32'd0);
        dec_ready = 1'b1;
        #1;
        cycle(); #1;
        chk("t2_drain_pc1",      if_pc, 32'd4);
        chk("t2_resume_valid",   32'(imem_req_valid), 32'd1);
        chk("t2_resume_addr",    imem_req_addr, 32'd16);
        for (int j = 2; j < 6; j++) begin
            cycle(); #1;
            chk("t2_drain_pc",    if_pc, 32'(4 * j));
            chk("t2_drain_instr", if_instr, 32'(4 * j));
        end

        // Redirect with two requests in flight
        do_reset();
        hold = 1'b1;
        #1;
        chk("t3_req_addr_c0", imem_req_addr, 32'd0);
        cycle(); #1;
        cycle(); #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        hold           = 1'b0;
        #1;
        chk("t3_redir_req_valid", 32'(imem_req_valid), 32'd0);
        cycle();
        redirect_valid = 1'b0;
        #1;
        chk("t3_req_valid_c3", 32'(imem_req_valid), 32'd1);
        chk("t3_req_addr_c3",  imem_req_addr, 32'h100);
        chk("t3_if_valid_c3",  32'(if_valid), 32'd0);
        cycle(); #1;
        chk("t3_if_valid_c4",  32'(if_valid), 32'd0);
        cycle(); #1;
        chk("t3_if_valid_c5",  32'(if_valid), 32'd0);
        cycle(); #1;
        chk("t3_if_pc_c6",     if_pc, 32'h100);
        chk("t3_if_instr_c6",  if_instr, 32'h100);
        cycle(); #1;
        chk("t3_if_pc_c7",     if_pc, 32'h104);

        // Unaligned redirect coinciding with a response and a pop
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        #1;
        chk("t4_redir_req_valid", 32'(imem_req_valid), 32'd0);
        cycle();
        redirect_valid = 1'b0;
        #1;
        chk("t4_req_addr",     imem_req_addr, 32'h200);
        chk("t5_cleared",      32'(if_valid), 32'd0);
        cycle(); #1;
        chk("t5_no_stale",     32'(if_valid), 32'd0);
        cycle(); #1;
        chk("t5_first_pc",     if_pc, 32'h200);
        chk("t5_first_instr",  if_instr, 32'h200);

        // PC wraps past the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        #1;
        cycle();
        redirect_valid = 1'b0;
        #1;
        chk("t6_top_addr",     imem_req_addr, 32'hFFFF_FFFC);
        chk("t6_top_if_valid", 32'(if_valid), 32'd0);
        cycle(); #1;
        chk("t6_wrap_addr",    imem_req_addr, 32'h0);
        cycle(); #1;
        chk("t6_top_if_pc",    if_pc, 32'hFFFF_FFFC);
        chk("t6_wrap_next",    imem_req_addr, 32'h4);
        cycle(); #1;
        chk("t6_wrap_if_pc",   if_pc, 32'h0);

        // Reset mid-stream
        rst = 1'b1;
        #1;
        chk("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
        cycle();
        #1;
        chk("t6_rst_if_valid",  32'(if_valid), 32'd0);
        chk("t6_rst_if_pc",     if_pc, 32'd0);
        pend.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        rst = 1'b0;
        #1;
        chk("t6_restart_valid", 32'(imem_req_valid), 32'd1);
        chk("t6_restart_addr",  imem_req_addr, 32'd0);
        cycle(); #1;
        cycle(); #1;
        chk("t6_restart_if_pc", if_pc, 32'd0);
        chk("t6_restart_if_v",  32'(if_valid), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
